// File: rtl/chan_scan_mux_pkg.sv
// Shared types for the channel scan multiplexer: mode pin encodings and the
// controller state enum, plus a helper mapping a state back to its mode.
package chan_scan_mux_pkg;

  // Encoding of the 2-bit mode input.
  typedef enum logic [1:0] {
    MODE_MANUAL = 2'b00,
    MODE_AUTO   = 2'b01,
    MODE_SWEEP  = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  // Controller states. SWEEP_DONE is the parked state after a finished sweep,
  // still belonging to the SWEEP mode but no longer stepping.
  typedef enum logic [2:0] {
    ST_MANUAL     = 3'd0,
    ST_AUTO       = 3'd1,
    ST_SWEEP      = 3'd2,
    ST_SWEEP_DONE = 3'd3,
    ST_HOLD       = 3'd4
  } state_e;

  // Mode a given state belongs to; used to detect a mode change.
  function automatic mode_e state_mode(input state_e st);
    mode_e m;
    m = MODE_MANUAL;
    case (st)
      ST_MANUAL:     m = MODE_MANUAL;
      ST_AUTO:       m = MODE_AUTO;
      ST_SWEEP:      m = MODE_SWEEP;
      ST_SWEEP_DONE: m = MODE_SWEEP;
      ST_HOLD:       m = MODE_HOLD;
      default:       m = MODE_MANUAL;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/chan_scan_mux_dwell_timer.sv
// Dwell timer: counts cycles spent on the current channel and flags when the
// programmed dwell has elapsed. The count wraps to zero on the cycle it is
// running and expired, so the owner steps exactly when 'expired' is seen.
module chan_scan_mux_dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell,
  output logic               expired
);

  logic [DWELL_W-1:0] count;

  // A ">=" compare, so lowering dwell below the running count steps at once.
  assign expired = (count >= dwell);

  // Dwell counter: clear has priority, otherwise count or wrap while running.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (run) begin
      count <= expired ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/chan_scan_mux.sv
// N-channel, W-bit registered multiplexer with manual selection, continuous
// auto-scan, one-shot sweep and hold. Channel stepping is paced by a
// programmable dwell timer; all outputs, including the pulses, are registered.
module chan_scan_mux
  import chan_scan_mux_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int W       = 1,
  parameter int DWELL_W = 8,
  localparam int SEL_W  = $clog2(NCH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [1:0]         mode,
  input  logic [SEL_W-1:0]   sel_in,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [NCH*W-1:0]   ch_in,
  output logic [W-1:0]       out_data,
  output logic [SEL_W-1:0]   out_ch,
  output logic               out_valid,
  output logic               sweep_done
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NCH - 1);

  // Channel data for an index; indices past the last channel read as zero.
  function automatic logic [W-1:0] pick(input logic [NCH*W-1:0] bus,
                                        input logic [SEL_W-1:0] idx);
    logic [W-1:0] d;
    d = '0;
    for (int k = 0; k < NCH; k++) begin
      if (idx == SEL_W'(k)) d = bus[k*W +: W];
    end
    return d;
  endfunction

  state_e             state_q, state_d;
  logic               sweep_armed_q, sweep_armed_d;
  logic [W-1:0]       out_data_d;
  logic [SEL_W-1:0]   out_ch_d;
  logic               out_valid_d;
  logic               sweep_done_d;

  mode_e              mode_cur;
  logic               mode_chg;
  logic [SEL_W-1:0]   ch_next;
  logic [W-1:0]       data_cur, data_next, data_sel;

  logic               tmr_clr, tmr_run, tmr_expired;

  assign mode_cur  = mode_e'(mode);
  assign mode_chg  = (mode_cur != state_mode(state_q));
  // Out-of-range channels (non-power-of-two NCH) also wrap to channel 0.
  assign ch_next   = (out_ch >= LAST_CH) ? '0 : out_ch + 1'b1;
  assign data_cur  = pick(ch_in, out_ch);
  assign data_next = pick(ch_in, ch_next);
  assign data_sel  = pick(ch_in, sel_in);

  chan_scan_mux_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .run     (tmr_run),
    .dwell   (dwell),
    .expired (tmr_expired)
  );

  // Next-state and next-output logic for every mode; ena=0 keeps all defaults.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; a missing default in always_comb would infer a latch.
  always_comb begin
    state_d       = state_q;
    sweep_armed_d = sweep_armed_q;
    out_data_d    = out_data;
    out_ch_d      = out_ch;
    out_valid_d   = 1'b0;
    sweep_done_d  = 1'b0;
    tmr_clr       = 1'b0;
    tmr_run       = 1'b0;

    if (ena) begin
      // Leaving SWEEP mode re-arms the one-shot sweep.
      if (mode_cur != MODE_SWEEP) sweep_armed_d = 1'b1;
      if (mode_chg) tmr_clr = 1'b1;

      case (mode_cur)
        MODE_MANUAL: begin
          state_d     = ST_MANUAL;
          out_ch_d    = sel_in;
          out_data_d  = data_sel;
          out_valid_d = mode_chg || (sel_in != out_ch);
          tmr_clr     = 1'b1;
        end

        MODE_AUTO: begin
          state_d = ST_AUTO;
          if (mode_chg) begin
            // Entry: stay on the current channel, restart the dwell.
            out_data_d  = data_cur;
            out_valid_d = 1'b1;
          end else begin
            tmr_run = 1'b1;
            if (tmr_expired) begin
              out_ch_d    = ch_next;
              out_data_d  = data_next;
              out_valid_d = 1'b1;
            end else begin
              out_data_d  = data_cur;
            end
          end
        end

        MODE_SWEEP: begin
          if (state_q == ST_SWEEP) begin
            tmr_run = 1'b1;
            if (tmr_expired) begin
              if (out_ch >= LAST_CH) begin
                // Last channel done: park with outputs frozen.
                state_d       = ST_SWEEP_DONE;
                sweep_done_d  = 1'b1;
                sweep_armed_d = 1'b0;
              end else begin
                out_ch_d    = ch_next;
                out_data_d  = data_next;
                out_valid_d = 1'b1;
              end
            end else begin
              out_data_d = data_cur;
            end
          end else if (state_q != ST_SWEEP_DONE) begin
            if (sweep_armed_q) begin
              // Sweep start: always from channel 0.
              state_d     = ST_SWEEP;
              out_ch_d    = '0;
              out_data_d  = ch_in[W-1:0];
              out_valid_d = 1'b1;
            end else begin
              state_d = ST_SWEEP_DONE;
            end
          end
        end

        MODE_HOLD: begin
          state_d = ST_HOLD;
        end

        default: begin
          state_d = ST_MANUAL;
        end
      endcase
    end
  end

  // State, arm flag and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_MANUAL;
      sweep_armed_q <= 1'b1;
      out_data      <= '0;
      out_ch        <= '0;
      out_valid     <= 1'b0;
      sweep_done    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sweep_armed_q <= sweep_armed_d;
      out_data      <= out_data_d;
      out_ch        <= out_ch_d;
      out_valid     <= out_valid_d;
      sweep_done    <= sweep_done_d;
    end
  end

endmodule
